otter_hazard_fwd: RTL
=====================

Name: otter_hazard_fwd

Overview:
Hazard and forwarding control stage for the pipelined OTTER core.
- Tracks the destination-register record of the instructions in EX, MEM and WB.
- Produces the 4-bit select codes for the two EX-stage ALU-operand forwarding muxes (4-to-1 generic mux, sel[3:0]).
- Produces the IF/ID stall and EX bubble/flush controls.
- Sits between decode and the EX operand muxes; drives their sel inputs directly.

Parameters:
- REG_AW, 5, register-address width (x0..x31).
- SEL_W, 4, width of the forwarding select outputs; must match the mux sel width.

Ports:
- CLK  in  1  core clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- id_valid  in  1  decode stage holds a valid instruction
- id_rs1  in  REG_AW  decode source register 1
- id_rs2  in  REG_AW  decode source register 2
- id_rd  in  REG_AW  decode destination register
- id_regwrite  in  1  decode instruction writes rd
- id_memread  in  1  decode instruction is a load
- ex_branch_taken  in  1  EX-stage branch/jump redirect this cycle
- fwd_sel_a  out  SEL_W  EX operand-A mux select
- fwd_sel_b  out  SEL_W  EX operand-B mux select
- stall_if  out  1  hold PC and IF/ID register
- stall_id  out  1  hold ID stage
- flush_id  out  1  invalidate IF/ID contents
- bubble_ex  out  1  insert NOP into ID/EX
- stall_cnt  out  32  stall-cycle count (only with the optional feature; otherwise tied 0)

Behaviour:
- Internal records for EX, MEM and WB each hold {valid, rd, regwrite, memread}. EX additionally holds rs1 and rs2. All records reset to zero asynchronously on RST_N low.
- Every rising edge without a stall, records shift: ID→EX, EX→MEM, MEM→WB.
  - ID→EX loads a zero record when bubble_ex=1 or id_valid=0.
- On a stall cycle, the EX record is loaded with a bubble, MEM and WB shift normally, and the ID inputs are not captured.
- Forwarding select uses only registered state, so there is no combinational path from the id_* inputs. Per operand, with rs the EX rs1 or rs2:
  - 1 (MEM ALU result) if MEM.valid & MEM.regwrite & MEM.rd==rs & rs!=0.
  - Otherwise 2 (WB data) if the same match holds against WB.
  - Otherwise 0 (register-file value).
  - Code 3 is never driven.
  - MEM has priority over WB.
- Load-use stall is combinational:
  - Condition: EX.valid & EX.memread & EX.rd!=0 & id_valid & (EX.rd==id_rs1 | EX.rd==id_rs2).
  - When true, stall_if=stall_id=bubble_ex=1 for exactly one cycle. On the next cycle the load is in MEM and forwarding code 2 resolves it via WB one cycle later. The stall lasts one cycle only because the EX record is now the bubble.
- Branch flush: ex_branch_taken=1 gives flush_id=1 and bubble_ex=1 in the same cycle. The ID record is discarded.
- Branch plus load-use in the same cycle: the branch wins. stall_if=stall_id=0 and flush_id=bubble_ex=1.
- Reset asserted mid-operation: all records clear immediately, all outputs go to 0 (sel=0, no stall/flush), and stall_cnt=0.
- x0 is never a forwarding or stall source.

Optional Feature:
- Macro: OTTER_HAZARD_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 each cycle stall_if=1. It saturates at 32'hFFFF_FFFF and clears on reset. Flush cycles are not counted.
- Undefined: no counter register; stall_cnt is driven constant 0.

Decomposition:
- Package otter_hazard_pkg:
  - typedef struct stage_rec_t {valid, rd, regwrite, memread}.
  - Localparams FWD_RF=0, FWD_MEM=1, FWD_WB=2 (SEL_W wide).
  - Localparam REG_AW.
- One sub-module, otter_fwd_sel: combinational compare of one operand rs against the MEM/WB records, returning the select code. It is instantiated twice (operands A and B).

Test Plan:
- Back-to-back ALU dependency: add x5 in EX→MEM, next instruction uses rs1=x5 → fwd_sel_a=1 and fwd_sel_b=0; no stall.
- Two-apart dependency: x6 written by WB, EX uses rs2=x6, MEM rd=x7 → fwd_sel_b=2; with MEM.rd=x6 as well → fwd_sel_b=1 (MEM priority).
- Load-use: lw x8 in EX, ID uses rs1=x8 → stall_if=stall_id=bubble_ex=1 for one cycle. The next cycle has no stall, then fwd_sel_a=2. With the macro defined, stall_cnt=1.
- x0 write: EX/MEM rd=0 with regwrite=1 and a consumer rs1=0 → fwd_sel_a=0, and no stall even when the producer is a load.
- Branch taken concurrent with load-use → flush_id=1, bubble_ex=1, stall_if=0; the next EX record is invalid, so both selects are 0.
- RST_N pulsed low mid-stall → all outputs 0 asynchronously; after release, the first valid instruction yields sel=0 and no stall.

Source files
------------

// File: rtl/otter_hazard_pkg.sv
// Shared types and constants for the OTTER hazard/forwarding stage.
// Optional stall counter: OTTER_HAZARD_STALL_CNT_EN (see otter_hazard_fwd.sv).
package otter_hazard_pkg;

  localparam int REG_AW = 5;
  localparam int SEL_W  = 4;

  localparam logic [SEL_W-1:0] FWD_RF  = 4'd0;
  localparam logic [SEL_W-1:0] FWD_MEM = 4'd1;
  localparam logic [SEL_W-1:0] FWD_WB  = 4'd2;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } stage_rec_t;

endpackage

// File: rtl/otter_fwd_sel.sv
// Forwarding select for one EX operand: compares rs against the MEM and WB
// destination records, with MEM taking priority over WB and x0 never forwarded.
module otter_fwd_sel
  import otter_hazard_pkg::*;
(
  input  logic [REG_AW-1:0] rs_i,
  input  stage_rec_t        mem_i,
  input  stage_rec_t        wb_i,
  output logic [SEL_W-1:0]  sel_o
);

  // Load-ness is irrelevant here; the load-use stall upstream already aligns loads with WB.
  logic unused_memread;
  assign unused_memread = mem_i.memread ^ wb_i.memread;

  always_comb begin
    sel_o = FWD_RF;
    if (rs_i != '0) begin
      if (mem_i.valid && mem_i.regwrite && (mem_i.rd == rs_i)) begin
        sel_o = FWD_MEM;
      end else if (wb_i.valid && wb_i.regwrite && (wb_i.rd == rs_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/otter_hazard_fwd.sv
// Hazard detection and operand forwarding control for the pipelined OTTER core.
// Define OTTER_HAZARD_STALL_CNT_EN to build the saturating stall-cycle counter.
module otter_hazard_fwd #(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_branch_taken,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic              stall_if,
  output logic              stall_id,
  output logic              flush_id,
  output logic              bubble_ex,
  output logic [31:0]       stall_cnt
);
  import otter_hazard_pkg::*;

  stage_rec_t        ex_q, ex_d, mem_q, wb_q;
  logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic              load_use;
  logic              stall;

  assign load_use = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && id_valid &&
                    ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

  // A taken branch discards the dependent instruction, so it overrides the stall.
  assign stall     = load_use && !ex_branch_taken;
  assign stall_if  = stall;
  assign stall_id  = stall;
  assign flush_id  = ex_branch_taken && RST_N;
  assign bubble_ex = (stall || ex_branch_taken) && RST_N;

  always_comb begin
    ex_d     = '0;
    ex_rs1_d = '0;
    ex_rs2_d = '0;
    if (id_valid && !bubble_ex) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = id_rd;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      ex_rs1_d      = id_rs1;
      ex_rs2_d      = id_rs2;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= ex_q;
      wb_q     <= mem_q;
      ex_rs1_q <= ex_rs1_d;
      ex_rs2_q <= ex_rs2_d;
    end
  end

  otter_fwd_sel u_fwd_a (
    .rs_i  (ex_rs1_q),
    .mem_i (mem_q),
    .wb_i  (wb_q),
    .sel_o (fwd_sel_a)
  );

  otter_fwd_sel u_fwd_b (
    .rs_i  (ex_rs2_q),
    .mem_i (mem_q),
    .wb_i  (wb_q),
    .sel_o (fwd_sel_b)
  );

`ifdef OTTER_HAZARD_STALL_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
